pc_seq_reg: RTL and testbench



---
 rtl/pc_pkg.sv | 17 +
 rtl/ras_stack.sv | 54 +++++
 rtl/pc_seq_reg.sv | 107 ++++++++++
 tb/tb_pc_seq_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared defaults and the select encoding for the program-counter register.
package pc_pkg;

  localparam int          PC_WIDTH         = 32;
  localparam int          INSTR_STEP       = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_SET_VECTOR   = 32'h0000_0080;

  typedef enum logic [2:0] {
    SEL_SET,
    SEL_HOLD,
    SEL_RET,
    SEL_JUMP,
    SEL_INC
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
// The overflow and underflow outputs are single-cycle pulses; the owner makes them sticky.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;

  // ptr is the next free slot, so the most recent entry sits one below it.
  assign top       = mem[ptr - PW'(1)];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_seq_reg.sv
// Program-counter register with set/stall/ret/jump/increment priority and a return-address stack.
// Optional target alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_seq_reg
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter int               STEP         = INSTR_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] SET_VECTOR   = WIDTH'(DEF_SET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             stall,
  input  logic             jump_valid,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign_err
);

  pc_sel_e          sel;
  logic             misalign;
  logic             target_misaligned;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ovf_pulse;
  logic             unf_pulse;

  assign pc_inc = pc + WIDTH'(STEP);

`ifdef PC_ALIGN_CHECK_EN
  assign target_misaligned = |(jump_target & WIDTH'(STEP - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        misalign_err <= 1'b0;
    else if (set)      misalign_err <= 1'b0;
    else if (misalign) misalign_err <= 1'b1;
  end
`else
  assign target_misaligned = 1'b0;
  assign misalign_err      = 1'b0;
`endif

  always_comb begin
    sel      = SEL_INC;
    misalign = 1'b0;
    if (set)             sel = SEL_SET;
    else if (stall)      sel = SEL_HOLD;
    else if (ret)        sel = SEL_RET;
    else if (jump_valid) begin
      // A rejected target degrades to a plain increment with no push.
      if (target_misaligned) misalign = 1'b1;
      else                   sel = SEL_JUMP;
    end
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_SET:  pc_next = SET_VECTOR;
      SEL_HOLD: pc_next = pc;
      SEL_RET:  pc_next = ras_empty ? pc_inc : ras_top;
      SEL_JUMP: pc_next = jump_target;
      default:  pc_next = pc_inc;
    endcase
  end

  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (sel == SEL_SET),
    .push      ((sel == SEL_JUMP) && call),
    .pop       (sel == SEL_RET),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ovf_pulse),
    .underflow (unf_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_VECTOR;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc <= pc_next;
      if (set) begin
        ras_overflow  <= 1'b0;
        ras_underflow <= 1'b0;
      end else begin
        ras_overflow  <= ras_overflow | ovf_pulse;
        ras_underflow <= ras_underflow | unf_pulse;
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_reg.sv
// Directed self-checking bench for pc_seq_reg (default build or with PC_ALIGN_CHECK_EN).
module tb_pc_seq_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set = 1'b0, stall = 1'b0, jump_valid = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, misalign_err;

  int errors = 0;
  int checks = 0;

  pc_seq_reg dut (
    .clk(clk), .reset(reset), .set(set), .stall(stall), .jump_valid(jump_valid),
    .call(call), .ret(ret), .jump_target(jump_target), .pc(pc),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set = 0; stall = 0; jump_valid = 0; call = 0; ret = 0;
  endtask

  task automatic jump_to(input logic [31:0] t);
    idle(); jump_valid = 1; jump_target = t;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    #2;
    reset = 1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    step();
    jump_to(32'h1234_5670);
    reset = 0;
    #2;
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow, misalign_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=%b",
               {ras_empty, ras_full, ras_overflow, ras_underflow, misalign_err}, 5'b10000);
    end
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== exp_pc[i]) begin errors++; $display("FAIL inc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
    end
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (pc !== 32'hC) begin errors++; $display("FAIL stall%0d got=%h exp=%h", i, pc, 32'hC); end
    end
    // Reset during a stall still wins immediately.
    reset = 0;
    #2;
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL reset_in_stall got=%h exp=%h", pc, 32'h0); end
    reset = 1;
    idle();
  endtask

  task automatic test_set();
    do_reset();
    ret = 1;
    step();
    idle();
    checks++;
    if (ras_underflow !== 1'b1 || pc !== 32'h4) begin
      errors++; $display("FAIL underflow_setup got=%b/%h exp=1/%h", ras_underflow, pc, 32'h4);
    end
    call = 1; jump_valid = 1; jump_target = 32'h40;
    step();
    idle();
    checks++;
    if (pc !== 32'h40 || ras_empty !== 1'b0) begin
      errors++; $display("FAIL set_setup got=%h/%b exp=%h/0", pc, ras_empty, 32'h40);
    end
    set = 1; stall = 1; jump_valid = 1; jump_target = 32'h300;
    step();
    idle();
    checks++;
    if (pc !== 32'h80) begin errors++; $display("FAIL set_pc got=%h exp=%h", pc, 32'h80); end
    checks++;
    if ({ras_empty, ras_overflow, ras_underflow} !== 3'b100) begin
      errors++; $display("FAIL set_flags got=%b exp=%b", {ras_empty, ras_overflow, ras_underflow}, 3'b100);
    end
  endtask

  task automatic test_call_ret();
    // Return addresses are caller pc + 4: 0x104 then 0x404.
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h400; exp_pc[1] = 32'h800; exp_pc[2] = 32'h404; exp_pc[3] = 32'h104;
    jump_to(32'h100);
    call = 1; jump_valid = 1; jump_target = 32'h400; step();
    checks++;
    if (pc !== exp_pc[0]) begin errors++; $display("FAIL call0 got=%h exp=%h", pc, exp_pc[0]); end
    jump_target = 32'h800; step();
    checks++;
    if (pc !== exp_pc[1]) begin errors++; $display("FAIL call1 got=%h exp=%h", pc, exp_pc[1]); end
    idle(); ret = 1;
    step();
    checks++;
    if (pc !== exp_pc[2]) begin errors++; $display("FAIL ret0 got=%h exp=%h", pc, exp_pc[2]); end
    step();
    checks++;
    if (pc !== exp_pc[3]) begin errors++; $display("FAIL ret1 got=%h exp=%h", pc, exp_pc[3]); end
    idle();
    checks++;
    if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
      errors++; $display("FAIL callret_empty got=%b/%b exp=1/0", ras_empty, ras_underflow);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pop [5];
    exp_pop[0] = 32'h44; exp_pop[1] = 32'h34; exp_pop[2] = 32'h24; exp_pop[3] = 32'h14; exp_pop[4] = 32'h18;
    do_reset();
    call = 1; jump_valid = 1;
    for (int i = 0; i < 5; i++) begin
      jump_target = 32'h10 * (i + 1);
      step();
      if (i == 3) begin
        checks++;
        if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin
          errors++; $display("FAIL full4 got=%b/%b exp=1/0", ras_full, ras_overflow);
        end
      end
    end
    idle();
    checks++;
    if (pc !== 32'h50 || ras_overflow !== 1'b1 || ras_full !== 1'b1) begin
      errors++; $display("FAIL overflow got=%h/%b/%b exp=%h/1/1", pc, ras_overflow, ras_full, 32'h50);
    end
    ret = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pc !== exp_pop[i]) begin errors++; $display("FAIL pop%0d got=%h exp=%h", i, pc, exp_pop[i]); end
    end
    idle();
    checks++;
    if (ras_underflow !== 1'b1 || ras_overflow !== 1'b1 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL sticky got=%b/%b/%b exp=1/1/1", ras_underflow, ras_overflow, ras_empty);
    end
  endtask

  task automatic test_wrap_priority();
    jump_to(32'hFFFF_FFFC);
    step();
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=%h", pc, 32'h0); end
    jump_to(32'h4C);
    call = 1; jump_valid = 1; jump_target = 32'h300;
    step();
    idle();
    ret = 1; jump_valid = 1; call = 1; jump_target = 32'h200;
    step();
    idle();
    checks++;
    if (pc !== 32'h50 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL ret_wins got=%h/%b exp=%h/1", pc, ras_empty, 32'h50);
    end
    // call without jump_valid is just an increment.
    call = 1;
    step();
    idle();
    checks++;
    if (pc !== 32'h54 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL call_nojump got=%h/%b exp=%h/1", pc, ras_empty, 32'h54);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_err;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc = 32'h14; exp_err = 1'b1;
`else
    exp_pc = 32'h202; exp_err = 1'b0;
`endif
    jump_to(32'h10);
    jump_to(32'h202);
    checks++;
    if (pc !== exp_pc || misalign_err !== exp_err) begin
      errors++; $display("FAIL misalign got=%h/%b exp=%h/%b", pc, misalign_err, exp_pc, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_call_ret();
    test_overflow();
    test_wrap_priority();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
